// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command controller: opcode bytes and the FSM state type.
package sys_ctrl_pkg;

  localparam logic [7:0] OP_WR      = 8'hAA;
  localparam logic [7:0] OP_RD      = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;
  localparam logic [7:0] OP_BRD     = 8'hEE;

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StRdTx, StBrAddr,
    StBrCnt, StBrIssue, StAluA, StAluB, StAluFn, StAluWait, StResTx
  } state_e;

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// Bundle of the UART RX, register-file, ALU and TX FIFO signals seen by the command controller.
interface sys_cmd_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FUN_W  = 4,
  parameter int unsigned RES_W  = 16
);
  logic [DATA_W-1:0] RX_P_DATA;
  logic              RX_P_VALID;
  logic [DATA_W-1:0] RD_D;
  logic              RD_D_VALID;
  logic [RES_W-1:0]  ALU_OUT;
  logic              ALU_OUT_VALID;
  logic              F_FULL;
  logic              CLK_G_EN;
  logic              WR_EN;
  logic              RD_EN;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WR_D;
  logic [FUN_W-1:0]  ALU_FUN;
  logic              ALU_EN;
  logic              W_INC;
  logic [DATA_W-1:0] TX_P_DATA;
  logic              BUSY;
  logic              ERR;

  modport master (
    input  RX_P_DATA, RX_P_VALID, RD_D, RD_D_VALID, ALU_OUT, ALU_OUT_VALID, F_FULL,
    output CLK_G_EN, WR_EN, RD_EN, ADDRESS, WR_D, ALU_FUN, ALU_EN, W_INC, TX_P_DATA,
           BUSY, ERR
  );

  modport slave (
    output RX_P_DATA, RX_P_VALID, RD_D, RD_D_VALID, ALU_OUT, ALU_OUT_VALID, F_FULL,
    input  CLK_G_EN, WR_EN, RD_EN, ADDRESS, WR_D, ALU_FUN, ALU_EN, W_INC, TX_P_DATA,
           BUSY, ERR
  );
endinterface

// File: rtl/sys_ctrl_timeout.sv
// Idle-cycle watchdog: counts while enabled, flags expiry on reaching TO_CYC (0 disables).
module sys_ctrl_timeout #(
  parameter int unsigned TO_CYC = 1023
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned CW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (TO_CYC != 0) && en && (cnt_q == CW'(TO_CYC));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (TO_CYC != 0) && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sys_cmd_ctrl.sv
// Framed byte-command decoder driving the register file, the ALU and the TX FIFO, with
// burst reads, FIFO back-pressure and an inter-byte timeout.
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FUN_W  = 4,
  parameter int unsigned RES_W  = 16,
  parameter int unsigned TO_CYC = 1023
) (
  input logic            CLK,
  input logic            RST,
  sys_cmd_ctrl_if.master bus
);
  localparam int unsigned NB = RES_W / DATA_W;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0] br_addr_q, br_addr_d;
  logic [DATA_W-1:0] br_left_q, br_left_d;
  logic              to_en, to_clr, to_exp;

  // States that wait on an input strobe and may therefore time out.
  assign to_en  = state_q inside {StWrAddr, StWrData, StRdAddr, StRdWait, StBrAddr, StBrCnt,
                                  StAluA, StAluB, StAluFn, StAluWait};
  assign to_clr = bus.RX_P_VALID || (state_d != state_q);

  sys_ctrl_timeout #(
    .TO_CYC (TO_CYC)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_exp)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rd_d          = rd_q;
    res_d         = res_q;
    idx_d         = idx_q;
    br_addr_d     = br_addr_q;
    br_left_d     = br_left_q;
    bus.CLK_G_EN  = 1'b0;
    bus.WR_EN     = 1'b0;
    bus.RD_EN     = 1'b0;
    bus.ADDRESS   = '0;
    bus.WR_D      = '0;
    bus.ALU_FUN   = '0;
    bus.ALU_EN    = 1'b0;
    bus.W_INC     = 1'b0;
    bus.TX_P_DATA = '0;
    bus.ERR       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.RX_P_VALID) begin
          case (bus.RX_P_DATA[7:0])
            OP_WR:      state_d = StWrAddr;
            OP_RD:      state_d = StRdAddr;
            OP_ALU_OP:  state_d = StAluA;
            OP_ALU_NOP: state_d = StAluFn;
            OP_BRD:     state_d = StBrAddr;
            default:    state_d = StIdle;
          endcase
        end
      end
      StWrAddr: if (bus.RX_P_VALID) begin
        addr_d  = bus.RX_P_DATA[ADDR_W-1:0];
        state_d = StWrData;
      end
      StWrData: if (bus.RX_P_VALID) begin
        bus.WR_EN   = 1'b1;
        bus.ADDRESS = addr_q;
        bus.WR_D    = bus.RX_P_DATA;
        state_d     = StIdle;
      end
      StRdAddr: if (bus.RX_P_VALID) begin
        bus.RD_EN   = 1'b1;
        bus.ADDRESS = bus.RX_P_DATA[ADDR_W-1:0];
        br_left_d   = '0;
        state_d     = StRdWait;
      end
      StRdWait: if (bus.RD_D_VALID) begin
        rd_d    = bus.RD_D;
        state_d = StRdTx;
      end
      StRdTx: begin
        bus.TX_P_DATA = rd_q;
        if (!bus.F_FULL) begin
          bus.W_INC = 1'b1;
          state_d   = (br_left_q != '0) ? StBrIssue : StIdle;
        end
      end
      StBrAddr: if (bus.RX_P_VALID) begin
        br_addr_d = bus.RX_P_DATA[ADDR_W-1:0];
        state_d   = StBrCnt;
      end
      StBrCnt: if (bus.RX_P_VALID) begin
        br_left_d = bus.RX_P_DATA;
        state_d   = (bus.RX_P_DATA == '0) ? StIdle : StBrIssue;
      end
      StBrIssue: begin
        bus.RD_EN   = 1'b1;
        bus.ADDRESS = br_addr_q;
        br_addr_d   = br_addr_q + ADDR_W'(1);
        br_left_d   = br_left_q - DATA_W'(1);
        state_d     = StRdWait;
      end
      StAluA, StAluB: if (bus.RX_P_VALID) begin
        bus.WR_EN   = 1'b1;
        bus.ADDRESS = (state_q == StAluB) ? ADDR_W'(1) : '0;
        bus.WR_D    = bus.RX_P_DATA;
        state_d     = (state_q == StAluB) ? StAluFn : StAluB;
      end
      StAluFn: begin
        bus.CLK_G_EN = 1'b1;
        if (bus.RX_P_VALID) begin
          bus.ALU_EN  = 1'b1;
          bus.ALU_FUN = bus.RX_P_DATA[FUN_W-1:0];
          state_d     = StAluWait;
        end
      end
      StAluWait: begin
        bus.CLK_G_EN = 1'b1;
        if (bus.ALU_OUT_VALID) begin
          res_d   = bus.ALU_OUT;
          idx_d   = '0;
          state_d = StResTx;
        end
      end
      StResTx: begin
        bus.CLK_G_EN  = 1'b1;
        bus.TX_P_DATA = res_q[int'(idx_q) * DATA_W +: DATA_W];
        if (!bus.F_FULL) begin
          bus.W_INC = 1'b1;
          if (idx_q == IW'(NB - 1)) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Every handled strobe changes state, so expiry only wins when the state would hold.
    if (to_exp && (state_d == state_q)) begin
      state_d   = StIdle;
      br_left_d = '0;
      bus.ERR   = 1'b1;
    end
  end

  assign bus.BUSY = (state_q != StIdle);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      br_addr_q <= '0;
      br_left_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      br_addr_q <= br_addr_d;
      br_left_q <= br_left_d;
    end
  end
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl: command stimulus pushes expected effects, a monitor
// pops and compares whenever the controller strobes an output.
module tb_sys_cmd_ctrl;
  localparam int unsigned TO_CYC = 16;

  logic CLK, RST;
  int   total = 0, bad = 0, cyc = 0;

  sys_cmd_ctrl_if #(.DATA_W(8), .ADDR_W(4), .FUN_W(4), .RES_W(16)) bus ();

  sys_cmd_ctrl #(
    .DATA_W (8),
    .ADDR_W (4),
    .FUN_W  (4),
    .RES_W  (16),
    .TO_CYC (TO_CYC)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected effects and environment state
  int          exp_wr[$], exp_rd[$], exp_fun[$], exp_push[$];
  logic [15:0] alu_q[$];
  logic [7:0]  rf[16];
  int          err_exp = 0, err_seen = 0;
  int          rd_lat_max = 0, alu_lat_max = 0;
  bit          ff_rand = 0, ff_hold = 0, gap_chk = 0;
  int          last_rd = -1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [30:0] outs();
    return {bus.CLK_G_EN, bus.WR_EN, bus.RD_EN, bus.ADDRESS, bus.WR_D, bus.ALU_FUN,
            bus.ALU_EN, bus.W_INC, bus.TX_P_DATA, bus.BUSY, bus.ERR};
  endfunction

  // Monitor
  int mon_e;
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (bus.WR_EN) begin
          mon_e = -1;
          if (exp_wr.size() != 0) mon_e = exp_wr.pop_front();
          chk("wr", int'({bus.ADDRESS, bus.WR_D}), mon_e);
        end
        if (bus.RD_EN) begin
          mon_e = -1;
          if (exp_rd.size() != 0) mon_e = exp_rd.pop_front();
          chk("rd_addr", int'(bus.ADDRESS), mon_e);
          if (gap_chk && last_rd >= 0) chk("br_gap", cyc - last_rd, 3);
          last_rd = cyc;
        end
        if (bus.ALU_EN) begin
          mon_e = -1;
          if (exp_fun.size() != 0) mon_e = exp_fun.pop_front();
          chk("alu_fun", int'(bus.ALU_FUN), mon_e);
        end
        if (bus.W_INC) begin
          mon_e = -1;
          if (exp_push.size() != 0) mon_e = exp_push.pop_front();
          chk("push", int'(bus.TX_P_DATA), mon_e);
          chk("winc_full", bus.F_FULL, 0);
        end
        if (bus.ERR) err_seen++;
      end
    end
  end

  // Register-file responder
  int          rf_n;
  logic [3:0]  rf_a;
  initial begin
    forever begin
      @(negedge CLK);
      if (RST && bus.RD_EN) begin
        rf_a = bus.ADDRESS;
        rf_n = $urandom_range(0, rd_lat_max);
        @(posedge CLK); #1;
        repeat (rf_n) begin @(posedge CLK); #1; end
        bus.RD_D = rf[rf_a];
        bus.RD_D_VALID = 1'b1;
        @(posedge CLK); #1;
        bus.RD_D_VALID = 1'b0;
      end
    end
  end

  // ALU responder
  int          alu_n;
  logic [15:0] alu_r;
  initial begin
    forever begin
      @(negedge CLK);
      if (RST && bus.ALU_EN) begin
        alu_r = 16'h0;
        if (alu_q.size() != 0) alu_r = alu_q.pop_front();
        alu_n = $urandom_range(0, alu_lat_max);
        @(posedge CLK); #1;
        repeat (alu_n) begin @(posedge CLK); #1; end
        bus.ALU_OUT = alu_r;
        bus.ALU_OUT_VALID = 1'b1;
        @(posedge CLK); #1;
        bus.ALU_OUT_VALID = 1'b0;
      end
    end
  end

  // FIFO full driver
  initial begin
    forever begin
      @(posedge CLK); #1;
      bus.F_FULL = ff_rand ? ($urandom_range(0, 3) == 0) : ff_hold;
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(posedge CLK); #1;
    bus.RX_P_VALID = 1'b1;
    bus.RX_P_DATA  = b;
    @(posedge CLK); #1;
    bus.RX_P_VALID = 1'b0;
    repeat (gap) @(posedge CLK);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge CLK); n++; end while (bus.BUSY && n < 400);
    chk(nm, bus.BUSY, 0);
  endtask

  task automatic wait_alu_valid();
    int n = 0;
    while (!bus.ALU_OUT_VALID && n < 60) begin @(negedge CLK); n++; end
    chk("alu_valid_seen", bus.ALU_OUT_VALID, 1);
  endtask

  // Expected effects of one command, computed from the command semantics.
  task automatic do_cmd(input int kind, input int gmax);
    logic [7:0]  a, d, b, f, n, j;
    logic [15:0] r;
    a = 8'($urandom); d = 8'($urandom); b = 8'($urandom); f = 8'($urandom);
    r = 16'($urandom);
    case (kind)
      0: begin
        exp_wr.push_back(((a % 16) << 8) | d);
        send(8'hAA, $urandom_range(0, gmax)); send(a, $urandom_range(0, gmax)); send(d, 0);
      end
      1: begin
        exp_rd.push_back(a % 16); exp_push.push_back(rf[a % 16]);
        send(8'hBB, $urandom_range(0, gmax)); send(a, 0);
      end
      2: begin
        exp_wr.push_back(d); exp_wr.push_back(256 | b); exp_fun.push_back(f % 16);
        alu_q.push_back(r); exp_push.push_back(r % 256); exp_push.push_back(r / 256);
        send(8'hCC, $urandom_range(0, gmax)); send(d, $urandom_range(0, gmax));
        send(b, $urandom_range(0, gmax)); send(f, 0);
      end
      3: begin
        exp_fun.push_back(f % 16); alu_q.push_back(r);
        exp_push.push_back(r % 256); exp_push.push_back(r / 256);
        send(8'hDD, $urandom_range(0, gmax)); send(f, 0);
      end
      4: begin
        n = 8'($urandom_range(0, 5));
        for (int i = 0; i < int'(n); i++) begin
          exp_rd.push_back((a + i) % 16); exp_push.push_back(rf[(a + i) % 16]);
        end
        send(8'hEE, $urandom_range(0, gmax)); send(a, $urandom_range(0, gmax)); send(n, 0);
      end
      default: begin
        do j = 8'($urandom); while (j inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE});
        send(j, 0);
      end
    endcase
    wait_idle($sformatf("idle_k%0d", kind));
  endtask

  initial begin
    RST = 1'b0;
    bus.RX_P_DATA = '0; bus.RX_P_VALID = 1'b0; bus.RD_D = '0; bus.RD_D_VALID = 1'b0;
    bus.ALU_OUT = '0; bus.ALU_OUT_VALID = 1'b0; bus.F_FULL = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 8'(8'h40 + i);
    repeat (3) @(posedge CLK);
    #1 chk("rst_outs", outs(), 0);
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK) chk("idle_outs", outs(), 0);

    // Plain write
    exp_wr.push_back((5 << 8) | 8'h3C);
    send(8'hAA, 0); send(8'h05, 0); send(8'h3C, 0);
    wait_idle("wr_idle");

    // ALU with operands, FIFO held full for 4 cycles after the result
    exp_wr.push_back(8'h10); exp_wr.push_back(256 | 8'h20); exp_fun.push_back(2);
    alu_q.push_back(16'hBEEF); exp_push.push_back(8'hEF); exp_push.push_back(8'hBE);
    ff_hold = 1'b1;
    send(8'hCC, 0); send(8'h10, 0); send(8'h20, 0); send(8'h02, 0);
    wait_alu_valid();
    repeat (4) begin @(negedge CLK); chk("winc_hold", bus.W_INC, 0); end
    ff_hold = 1'b0;
    @(negedge CLK) chk("alu_push0", bus.W_INC, 1);
    @(negedge CLK) chk("alu_push1", bus.W_INC, 1);
    wait_idle("alu_idle");

    // Burst read with wrap, zero-latency register file
    gap_chk = 1'b1; last_rd = -1;
    exp_rd.push_back(14); exp_rd.push_back(15); exp_rd.push_back(0);
    exp_push.push_back(8'h4E); exp_push.push_back(8'h4F); exp_push.push_back(8'h40);
    send(8'hEE, 0); send(8'h0E, 0); send(8'h03, 0);
    wait_idle("br_idle");
    gap_chk = 1'b0;

    // Zero-length burst
    send(8'hEE, 0); send(8'h02, 0); send(8'h00, 0);
    wait_idle("br0_idle");

    // Timeout in WR_DATA, then a normal read
    err_exp++;
    send(8'hAA, 0); send(8'h03, 0);
    wait_idle("to_idle");
    chk("to_err_cnt", err_seen, 1);
    exp_rd.push_back(7); exp_push.push_back(8'h47);
    send(8'hBB, 0); send(8'h07, 0);
    wait_idle("rd_after_to");

    // Reset during RES_TX after the first byte
    exp_fun.push_back(5); alu_q.push_back(16'h1234); exp_push.push_back(8'h34);
    send(8'hDD, 0); send(8'h05, 0);
    wait_alu_valid();
    @(negedge CLK) chk("alu_lat", bus.W_INC, 1);
    @(posedge CLK); #1 RST = 1'b0;
    #1 chk("rst_mid_outs", outs(), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    chk("post_rst_busy", bus.BUSY, 0);

    // Randomised traffic with back-pressure and variable latencies
    for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
    rd_lat_max = 2; alu_lat_max = 3; ff_rand = 1'b1;
    for (int k = 0; k < 40; k++) do_cmd($urandom_range(0, 5), 3);
    ff_rand = 1'b0;
    repeat (4) @(negedge CLK);

    chk("wr_left", exp_wr.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    chk("fun_left", exp_fun.size(), 0);
    chk("push_left", exp_push.size(), 0);
    chk("err_total", err_seen, err_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
